// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream and holds the fetch stage until a full image is in place.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int         ADDR_BITS  = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         MEM_DEPTH  = 64,
    parameter logic [7:0] CMD_LOAD   = 8'h4C
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_mem_wr_en,
    output logic [ADDR_BITS-1:0]  o_mem_wr_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wr_data,
    output logic                  o_pc_reset_out,
    output logic                  o_pc_enable_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int BPW  = DATA_WIDTH / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNT   = 3'd1,
        S_DATA    = 3'd2,
        S_CHECK   = 3'd3,
        S_RELEASE = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [BC_W-1:0]       r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]            r_word_idx, w_word_idx_nxt;
    logic [7:0]            r_word_cnt, w_word_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_shift_in;
    logic                  w_n_bad;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_pc_reset, w_pc_reset_nxt;
    logic                  r_pc_enable, w_pc_enable_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_error, w_error_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum, w_csum_nxt;
`endif

    // Word assembled with the incoming byte as least significant (MSB-first stream)
    assign w_shift_in = DATA_WIDTH'({r_shift, i_rx_data});
    assign w_n_bad    = (i_rx_data == 8'd0) || (32'(i_rx_data) > 32'(MEM_DEPTH));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_word_idx_nxt  = r_word_idx;
        w_word_cnt_nxt  = r_word_cnt;
        w_shift_nxt     = r_shift;
        w_wr_en_nxt     = 1'b0;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_pc_reset_nxt  = r_pc_reset;
        w_pc_enable_nxt = r_pc_enable;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_csum_nxt      = r_csum;
`endif
        case (r_state)
            S_IDLE, S_ERROR: begin
                if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
                    w_state_nxt     = S_COUNT;
                    w_error_nxt     = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_pc_reset_nxt  = 1'b1;
                    w_pc_enable_nxt = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_COUNT: begin
                if (i_rx_valid && w_n_bad) begin
                    w_state_nxt = S_ERROR;
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else if (i_rx_valid) begin
                    w_state_nxt    = S_DATA;
                    w_word_cnt_nxt = i_rx_data;
                    w_word_idx_nxt = 8'd0;
                    w_byte_cnt_nxt = {BC_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_nxt     = 8'd0;
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    w_shift_nxt = w_shift_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_nxt  = r_csum ^ i_rx_data;
`endif
                    if (r_byte_cnt == BC_W'(BPW - 1)) begin
                        w_wr_en_nxt    = 1'b1;
                        w_addr_nxt     = ADDR_BITS'(r_word_idx) * ADDR_BITS'(BPW);
                        w_data_nxt     = w_shift_in;
                        w_word_idx_nxt = r_word_idx + 8'd1;
                        w_byte_cnt_nxt = {BC_W{1'b0}};
                        if (r_word_idx == (r_word_cnt - 8'd1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            w_state_nxt = S_CHECK;
`else
                            w_state_nxt = S_RELEASE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
`endif
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (i_rx_valid && (i_rx_data == r_csum)) begin
                    w_state_nxt = S_RELEASE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else if (i_rx_valid) begin
                    w_state_nxt = S_ERROR;
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
`endif
            S_RELEASE: begin
                // Any byte arriving here is dropped; the CPU is let go next cycle
                w_state_nxt     = S_IDLE;
                w_pc_reset_nxt  = 1'b0;
                w_pc_enable_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt  <= {BC_W{1'b0}};
            r_word_idx  <= 8'd0;
            r_word_cnt  <= 8'd0;
            r_shift     <= {DATA_WIDTH{1'b0}};
            r_wr_en     <= 1'b0;
            r_addr      <= {ADDR_BITS{1'b0}};
            r_data      <= {DATA_WIDTH{1'b0}};
            r_pc_reset  <= 1'b1;
            r_pc_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_pc_reset  <= w_pc_reset_nxt;
            r_pc_enable <= w_pc_enable_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
`endif
        end
    end

    assign o_mem_wr_en     = r_wr_en;
    assign o_mem_wr_addr   = r_addr;
    assign o_mem_wr_data   = r_data;
    assign o_pc_reset_out  = r_pc_reset;
    assign o_pc_enable_out = r_pc_enable;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-stream reference model checked every cycle, plus directed literal checks.
module tb_imem_loader;
    localparam int         AW    = 32;
    localparam int         DW    = 32;
    localparam int         DEPTH = 64;
    localparam int         BPW   = DW / 8;
    localparam logic [7:0] CMD   = 8'h4C;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          pc_reset, pc_enable, busy, done, error;

    imem_loader #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .CMD_LOAD(CMD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data),
        .o_pc_reset_out(pc_reset), .o_pc_enable_out(pc_enable),
        .o_busy(busy), .o_done(done), .o_error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int last_done_cyc = -1;
    int pce_rise_cyc  = -1;
    logic prev_pce = 1'b0;
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];

    // reference model: a load is a header, a count, then N*BPW data bytes (+ checksum)
    bit            m_in_load, m_have_n, m_rel;
    int            m_n;
    logic [7:0]    m_bytes[$];
    logic          exp_wr_en, exp_pcr, exp_pce, exp_busy, exp_done, exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_in_load = 1'b0; m_have_n = 1'b0; m_rel = 1'b0; m_n = 0; m_bytes.delete();
        exp_wr_en = 1'b0; exp_addr = '0; exp_data = '0; exp_pcr = 1'b1; exp_pce = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic [7:0] d);
        logic [7:0]    x;
        logic [DW-1:0] w;
        int            k;
        exp_wr_en = 1'b0;
        exp_done  = 1'b0;
        if (m_rel) begin
            m_rel = 1'b0; exp_pcr = 1'b0; exp_pce = 1'b1;
            return;
        end
        if (!v) return;
        if (!m_in_load) begin
            if (d == CMD) begin
                m_in_load = 1'b1; m_have_n = 1'b0; m_bytes.delete();
                exp_err = 1'b0; exp_busy = 1'b1; exp_pcr = 1'b1; exp_pce = 1'b0;
            end
            return;
        end
        if (!m_have_n) begin
            if (d == 8'd0 || int'(d) > DEPTH) begin
                m_in_load = 1'b0; exp_err = 1'b1; exp_busy = 1'b0;
            end else begin
                m_have_n = 1'b1; m_n = int'(d);
            end
            return;
        end
        if (m_bytes.size() < m_n * BPW) begin
            m_bytes.push_back(d);
            if (m_bytes.size() % BPW == 0) begin
                k = m_bytes.size() / BPW - 1;
                w = '0;
                for (int j = 0; j < BPW; j++) w = (w << 8) | DW'(m_bytes[k*BPW + j]);
                exp_wr_en = 1'b1; exp_addr = AW'(k * BPW); exp_data = w;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (m_bytes.size() == m_n * BPW) begin
                    m_in_load = 1'b0; m_rel = 1'b1; exp_done = 1'b1; exp_busy = 1'b0;
                end
`endif
            end
        end else begin
            x = 8'd0;
            foreach (m_bytes[j]) x ^= m_bytes[j];
            m_in_load = 1'b0;
            exp_busy  = 1'b0;
            if (d == x) begin
                m_rel = 1'b1; exp_done = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
    endfunction

    // compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("wr_en",     64'(wr_en),     64'(exp_wr_en));
            chk("wr_addr",   64'(wr_addr),   64'(exp_addr));
            chk("wr_data",   64'(wr_data),   64'(exp_data));
            chk("pc_reset",  64'(pc_reset),  64'(exp_pcr));
            chk("pc_enable", 64'(pc_enable), 64'(exp_pce));
            chk("busy",      64'(busy),      64'(exp_busy));
            chk("done",      64'(done),      64'(exp_done));
            chk("error",     64'(error),     64'(exp_err));
        end
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        if (done) last_done_cyc = cyc;
        if (pc_enable && !prev_pce) pce_rise_cyc = cyc;
        prev_pce = pc_enable;
    end

    task automatic cycle(input logic v, input logic [7:0] d);
        @(negedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        model_step(v, d);
    endtask

    task automatic send(input logic [7:0] d, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom));
        end
        cycle(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // count byte plus body; checksum is appended when the feature is built in
    task automatic send_body(input int n, input bit gaps, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        send(8'(n), gaps);
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n * BPW; i++) begin
                b = 8'($urandom);
                x ^= b;
                send(b, gaps);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send(corrupt ? (x ^ 8'h01) : x, gaps);
`else
            if (corrupt) x = 8'd0;
`endif
        end
    endtask

    initial begin
        int nw;
        int dd_cyc;
        int n;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_reset", 64'(pc_reset), 64'd1);
        chk("rst_pc_enable", 64'(pc_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // junk in IDLE is ignored
        cycle(1'b1, 8'h00); cycle(1'b1, 8'hFF); idle(2);
        chk("idle_busy", 64'(busy), 64'd0);

        // directed two-word load
        nw = wq_addr.size();
        send(CMD, 1'b0); send(8'h02, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h13, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h13, 1'b0);
`endif
        dd_cyc = cyc;
        idle(3);
        chk("dir_nwrites", 64'(wq_addr.size() - nw), 64'd2);
        if (wq_addr.size() >= nw + 2) begin
            chk("dir_addr0", 64'(wq_addr[nw]), 64'h0);
            chk("dir_data0", 64'(wq_data[nw]), 64'h00000013);
            chk("dir_addr1", 64'(wq_addr[nw+1]), 64'h4);
            chk("dir_data1", 64'(wq_data[nw+1]), 64'hAABBCCDD);
        end
        chk("dir_done_time", 64'(last_done_cyc), 64'(dd_cyc + 1));
        chk("dir_pce_time", 64'(pce_rise_cyc), 64'(dd_cyc + 2));

        // new header while running halts the CPU on the next cycle
        send(CMD, 1'b0); idle(1);
        chk("rerun_pce", 64'(pc_enable), 64'd0);
        chk("rerun_pcr", 64'(pc_reset), 64'd1);
        chk("rerun_busy", 64'(busy), 64'd1);
        send_body(1, 1'b0, 1'b0); idle(3);

        // bad counts
        nw = wq_addr.size();
        send(CMD, 1'b0); send(8'h00, 1'b0); idle(1);
        chk("n0_error", 64'(error), 64'd1);
        send(CMD, 1'b0); send(8'h41, 1'b0); idle(1);
        chk("n65_error", 64'(error), 64'd1);
        chk("bad_n_nowrite", 64'(wq_addr.size() - nw), 64'd0);
        send(CMD, 1'b0); send_body(1, 1'b0, 1'b0); idle(2);
        chk("recover_error", 64'(error), 64'd0);
        chk("recover_pce", 64'(pc_enable), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        send(CMD, 1'b0); send(8'h01, 1'b0);
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b0);
        send(8'h08, 1'b0); dd_cyc = cyc; idle(3);
        chk("ck_done_time", 64'(last_done_cyc), 64'(dd_cyc + 1));
        send(CMD, 1'b0); send(8'h01, 1'b0);
        send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'h78, 1'b0);
        send(8'h09, 1'b0); idle(3);
        chk("ck_bad_error", 64'(error), 64'd1);
        chk("ck_bad_pce", 64'(pc_enable), 64'd0);
`endif

        // reset after the 3rd byte of word 1
        send(CMD, 1'b0); send(8'h02, 1'b0);
        for (int i = 0; i < 7; i++) send(8'(8'h30 + i), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0; rx_valid = 1'b0;
        #1;
        nw = wq_addr.size();
        chk("mid_rst_pcr", 64'(pc_reset), 64'd1);
        chk("mid_rst_pce", 64'(pc_enable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_data", 64'(wr_data), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        chk("mid_rst_nowrite", 64'(wq_addr.size() - nw), 64'd0);

        // maximum count: last address with no wrap
        send(CMD, 1'b0); send_body(DEPTH, 1'b0, 1'b0); idle(3);
        chk("max_last_addr", 64'(wq_addr[wq_addr.size()-1]), 64'(AW'((DEPTH - 1) * BPW)));

        // randomized loads with gaps, junk, bad counts and bad checksums
        for (int it = 0; it < 30; it++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                if (jb == CMD) jb = 8'h00;
                cycle(1'($urandom), jb);
            end
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = $urandom_range(DEPTH + 1, 255);
                default: n = $urandom_range(1, 6);
            endcase
            send(CMD, 1'b1);
            send_body(n, 1'b1, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory from a byte stream and holds the fetch stage while it does so. It sits between the byte receiver (UART/debug link) and the instruction memory write port. It drives the PC reset and enable inputs of the fetch stage, so the processor starts executing only after a complete, valid program image has been written.

## Interface

- ADDR_BITS, 32, width of write address (byte address, same space as the PC)
- DATA_WIDTH, 32, instruction word width; multiple of 8; BPW = DATA_WIDTH/8 bytes per word
- MEM_DEPTH, 64, instruction memory depth in words; maximum accepted word count
- CMD_LOAD, 8'h4C, header byte that starts a load

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- mem_wr_en  out  1  one-cycle instruction-memory write strobe
- mem_wr_addr  out  ADDR_BITS  byte address = word_index*BPW
- mem_wr_data  out  DATA_WIDTH  assembled instruction word
- pc_reset_out  out  1  to fetch-stage PC reset, active-high
- pc_enable_out  out  1  to fetch-stage PC enable
- busy  out  1  high from the accepted header until leaving the load states
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky load-failure flag

## Operation

- States: IDLE, COUNT, DATA, CHECK (only with macro), RELEASE, ERROR.
- Reset values: state IDLE, pc_reset_out=1, pc_enable_out=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, error=0. The CPU stays halted until the first good load.
- IDLE or ERROR: a byte equal to CMD_LOAD -> COUNT. On entry: error cleared, busy=1, pc_reset_out=1, pc_enable_out=0. Other bytes are ignored.
- COUNT: the next byte is N, the word count.
  - N==0 or N>MEM_DEPTH -> ERROR.
  - Otherwise -> DATA with word_index=0 and byte_cnt=0.
- DATA: bytes are shifted in MSB first.
  - When byte_cnt reaches BPW-1: register the word, pulse mem_wr_en, increment word_index, clear byte_cnt.
  - After word N-1: go to CHECK (macro defined) or RELEASE.
- RELEASE: lasts one cycle.
  - done=1, pc_reset_out=1, busy=0.
  - Next cycle: IDLE with pc_reset_out=0, pc_enable_out=1.
  - rx_valid during RELEASE is dropped.
- ERROR: error=1, busy=0, pc_reset_out=1, pc_enable_out=0. The CPU stays halted; a new header restarts the load.
- Between complete words, mem_wr_addr and mem_wr_data hold their last value. Partial words are never written.
- Reset mid-load: returns to the reset values immediately. Memory contents are left as written; the CPU stays halted.

## Timing

- mem_wr_en rises the cycle after the rx_valid carrying the last byte of a word. The address and data are valid in that same cycle.
- done is asserted the cycle after the final byte (no macro) or after the checksum byte (macro). pc_enable_out rises one cycle later.
- The header's own rx_valid cycle is followed by pc_enable_out=0 on the next edge.
- Back-to-back rx_valid on consecutive cycles is fully supported; there is no backpressure.
- word_index counts up to N-1 only. With N=MEM_DEPTH, the last address is (MEM_DEPTH-1)*BPW and there is no wrap.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word, CHECK expects one byte equal to the XOR of all data bytes.
  - Match -> RELEASE.
  - Mismatch -> ERROR. Words already written stay in memory; the CPU stays halted.
- Not defined: there is no CHECK state and no checksum byte. The last word goes directly to RELEASE.

## Test plan

- After reset: pc_reset_out=1, pc_enable_out=0, all other outputs 0. Bytes 0x00 and 0xFF while in IDLE -> no state change.
- Stream 4C,02,00,00,00,13,AA,BB,CC,DD (no macro):
  - Writes 0x00000013 at address 0, then 0xAABBCCDD at address 4.
  - done pulses the cycle after byte DD; pc_enable_out=1 one cycle later.
- Stream 4C,00 -> error=1, no writes. Stream 4C,41 with MEM_DEPTH=64 -> error=1, no writes. A following valid load clears error.
- With the macro: stream 4C,01,12,34,56,78,08 -> checksum matches, done pulses. Same stream with last byte 09 -> error=1, pc_enable_out stays 0.
- Reset asserted after the 3rd data byte of word 1 -> outputs return to reset values at once. No write for the partial word.
- A new header while running (pc_enable_out=1) -> pc_enable_out=0 and pc_reset_out=1 on the next cycle, busy=1.
